// File: rtl/apb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : apb_rr_arbiter_if
// Requester handshake plus APB master bus of the round-robin APB arbiter.
// Revision  : 1.0
// ============================================================================
interface apb_rr_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int SLV_ADDR_WIDTH = 2
);
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*SLV_ADDR_WIDTH-1:0] req_slv;
  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_REQ-1:0]                req_wr;
  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata;
  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_REQ-1:0]                done;
  logic [DATA_WIDTH-1:0]             rdata;
  logic                              err;
  logic                              psel1;
  logic                              psel2;
  logic                              penable;
  logic [ADDR_WIDTH-1:0]             paddr;
  logic                              pwrite;
  logic [DATA_WIDTH-1:0]             pwdata;
  logic [DATA_WIDTH-1:0]             prdata;
  logic                              pready;

  modport master (
    input  req, req_slv, req_addr, req_wr, req_wdata, prdata, pready,
    output gnt, done, rdata, err, psel1, psel2, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req, req_slv, req_addr, req_wr, req_wdata, prdata, pready,
    input  gnt, done, rdata, err, psel1, psel2, penable, paddr, pwrite, pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_arbiter
// Round-robin sequencer sharing one APB master port, with pready timeout.
// Revision : 1.0
// ============================================================================
module apb_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int SLV_ADDR_WIDTH = 2,
  parameter int TIMEOUT        = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_rr_arbiter_if.master      bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    psel1_q, psel1_d;
  logic                    psel2_q, psel2_d;
  logic                    penable_q, penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          cand;
  logic [SLV_ADDR_WIDTH-1:0] win_slv;
  logic [NUM_REQ-1:0]        win_oh;
  logic [NUM_REQ-1:0]        owner_oh;
  logic                      launch;

  // Search starts one past the last winner so the previous owner ranks lowest.
  always_comb begin : rr_search
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_slv  = bus.req_slv[win_idx*SLV_ADDR_WIDTH +: SLV_ADDR_WIDTH];
  assign win_oh   = NUM_REQ'(1) << win_idx;
  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_comb begin : next_state
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    launch    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        launch    = win_found;
      end
      S_SETUP: begin
        // No psel in SETUP means the slave select did not decode.
        if (psel1_q || psel2_q) begin
          state_d   = S_ACCESS;
          penable_d = 1'b1;
          cnt_d     = '0;
        end else begin
          state_d = S_DONE;
          done_d  = owner_oh;
          err_d   = 1'b1;
        end
      end
      S_ACCESS: begin
        if (bus.pready) begin
          done_d    = owner_oh;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          if (!pwrite_q) rdata_d = bus.prdata;
          state_d   = S_IDLE;
          launch    = win_found;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d    = owner_oh;
          err_d     = 1'b1;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d   = S_SETUP;
      last_d    = win_idx;
      owner_d   = win_idx;
      gnt_d     = win_oh;
      paddr_d   = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      pwrite_d  = bus.req_wr[win_idx];
      if (bus.req_wr[win_idx]) pwdata_d = bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
      psel1_d   = (win_slv == SLV_ADDR_WIDTH'(1));
      psel2_d   = (win_slv == SLV_ADDR_WIDTH'(2));
      penable_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.psel1   = psel1_q;
  assign bus.psel2   = psel2_q;
  assign bus.penable = penable_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.pwdata  = pwdata_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_rr_arbiter
// Self-checking bench: directed vector table, corner sequences, random traffic.
// Revision : 1.0
// ============================================================================
module tb_apb_rr_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int TO = 16;
  localparam int IW = 2;

  logic pclk;
  logic presetn;

  apb_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_ADDR_WIDTH(SW)) bus();

  apb_rr_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLV_ADDR_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transfer-level view of the arbiter built from the protocol rules.
  int            m_phase;   // 0 idle, 1 setup, 2 access, 3 error-done
  int            m_owner;
  int            m_last;
  int            m_wait;
  logic          m_wr;
  logic          m_ok;
  logic [NR-1:0] e_gnt, e_done;
  logic          e_err, e_p1, e_p2, e_pen;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;

  function automatic int rr_pick(input int last, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++)
      if (r[IW'((last + k) % NR)]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = NR - 1; m_wait = 0; m_wr = 1'b0; m_ok = 1'b0;
    e_gnt = '0; e_done = '0; e_err = 1'b0; e_p1 = 1'b0; e_p2 = 1'b0; e_pen = 1'b0;
    e_rdata = '0; e_wdata = '0; e_addr = '0;
  endtask

  task automatic model_step();
    bit            arb;
    int            w;
    logic [SW-1:0] s;
    arb = 1'b0;
    e_gnt = '0; e_done = '0; e_err = 1'b0;
    case (m_phase)
      0: begin e_p1 = 1'b0; e_p2 = 1'b0; e_pen = 1'b0; arb = 1'b1; end
      1: begin
        if (m_ok) begin e_pen = 1'b1; m_wait = 0; m_phase = 2; end
        else begin e_done = NR'(1) << m_owner; e_err = 1'b1; m_phase = 3; end
      end
      2: begin
        m_wait++;
        if (bus.pready) begin
          e_done = NR'(1) << m_owner;
          if (!m_wr) e_rdata = bus.prdata;
          e_p1 = 1'b0; e_p2 = 1'b0; e_pen = 1'b0; m_phase = 0; arb = 1'b1;
        end else if (m_wait == TO) begin
          e_done = NR'(1) << m_owner; e_err = 1'b1;
          e_p1 = 1'b0; e_p2 = 1'b0; e_pen = 1'b0; m_phase = 3;
        end
      end
      default: m_phase = 0;
    endcase
    if (arb) begin
      w = rr_pick(m_last, bus.req);
      if (w >= 0) begin
        s       = bus.req_slv[w*SW +: SW];
        m_last  = w;
        m_owner = w;
        m_phase = 1;
        e_gnt   = NR'(1) << w;
        m_ok    = (s == 2'b01) || (s == 2'b10);
        e_p1    = (s == 2'b01);
        e_p2    = (s == 2'b10);
        e_pen   = 1'b0;
        m_wr    = bus.req_wr[w];
        e_addr  = bus.req_addr[w*AW +: AW];
        if (m_wr) e_wdata = bus.req_wdata[w*DW +: DW];
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt", 32'(bus.gnt), 32'(e_gnt));
    chk("done", 32'(bus.done), 32'(e_done));
    if (e_done != '0) chk("err", 32'(bus.err), 32'(e_err));
    chk("rdata", 32'(bus.rdata), 32'(e_rdata));
    chk("psel1", 32'(bus.psel1), 32'(e_p1));
    chk("psel2", 32'(bus.psel2), 32'(e_p2));
    chk("penable", 32'(bus.penable), 32'(e_pen));
    if (e_p1 || e_p2) begin
      chk("paddr", 32'(bus.paddr), 32'(e_addr));
      chk("pwrite", 32'(bus.pwrite), 32'(m_wr));
      if (m_wr) chk("pwdata", 32'(bus.pwdata), 32'(e_wdata));
    end
    chk("psel_exclusive", 32'(bus.psel1 & bus.psel2), 32'd0);
    chk("penable_one_psel", 32'(bus.penable & ~(bus.psel1 ^ bus.psel2)), 32'd0);
  endtask

  task automatic tick();
    @(posedge pclk);
    if (presetn) model_step();
    @(negedge pclk);
    check_outputs();
  endtask

  task automatic reset_dut();
    @(negedge pclk);
    presetn = 1'b0;
    bus.req = '0; bus.pready = 1'b0;
    model_reset();
    @(negedge pclk);
    check_outputs();
    presetn = 1'b1;
  endtask

  task automatic set_fields(input int i, input logic [SW-1:0] s, input logic [AW-1:0] a,
                            input logic w, input logic [DW-1:0] d);
    bus.req_slv[i*SW +: SW]   = s;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wr[i +: 1]        = w;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_fields(input int i);
    int r;
    logic [SW-1:0] s;
    r = $urandom_range(0, 7);
    s = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b00;
    set_fields(i, s, AW'($urandom), 1'($urandom), DW'($urandom));
  endtask

  typedef struct {
    int        id;
    logic [1:0] slv;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] prd;
    int         rlat;      // ACCESS cycles before pready rises
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_lat;   // cycles from gnt to done
    int         exp_acc;   // ACCESS cycles observed
    logic       exp_p1;
    logic       exp_p2;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int lat, acc;
    bit got, seen1, seen2, seen_any;
    logic [AW-1:0] addr_seen;
    logic          wr_seen;
    set_fields(v.id, v.slv, v.addr, v.wr, v.wdata);
    bus.prdata = v.prd;
    bus.pready = 1'b0;
    bus.req    = NR'(1) << v.id;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      tick();
      if (bus.gnt != '0) got = 1'b1;
    end
    chk("vec_gnt", 32'(bus.gnt), 32'd1 << v.id);
    bus.req = '0;
    lat = 0; acc = 0; got = 1'b0; seen1 = 1'b0; seen2 = 1'b0; seen_any = 1'b0;
    addr_seen = '0; wr_seen = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if ((bus.psel1 || bus.psel2) && !seen_any) begin
        seen_any = 1'b1; addr_seen = bus.paddr; wr_seen = bus.pwrite;
      end
      if (bus.psel1) seen1 = 1'b1;
      if (bus.psel2) seen2 = 1'b1;
      if (bus.penable) acc++;
      bus.pready = bus.penable && (acc > v.rlat);
      tick();
      lat++;
      if (bus.done != '0) got = 1'b1;
    end
    chk("vec_done", 32'(bus.done), 32'd1 << v.id);
    chk("vec_err", 32'(bus.err), 32'(v.exp_err));
    chk("vec_rdata", 32'(bus.rdata), 32'(v.exp_rdata));
    chk("vec_latency", 32'(lat), 32'(v.exp_lat));
    chk("vec_access_cycles", 32'(acc), 32'(v.exp_acc));
    chk("vec_psel1_seen", 32'(seen1), 32'(v.exp_p1));
    chk("vec_psel2_seen", 32'(seen2), 32'(v.exp_p2));
    if (seen_any) begin
      chk("vec_paddr", 32'(addr_seen), 32'(v.addr));
      chk("vec_pwrite", 32'(wr_seen), 32'(v.wr));
    end
    bus.pready = 1'b0;
  endtask

  initial begin
    int ng, last_k;
    bit got;
    logic [NR-1:0] g;

    //          id slv    addr   wr wdata  prd    rlat err rdata  lat acc p1 p2
    vecs[0] = '{0, 2'b01, 8'h10, 1, 8'hA5, 8'h00, 0,   0, 8'h00, 2,  1,  1, 0};
    vecs[1] = '{0, 2'b01, 8'h10, 0, 8'h00, 8'hA5, 0,   0, 8'hA5, 2,  1,  1, 0};
    vecs[2] = '{2, 2'b11, 8'h20, 1, 8'h11, 8'h00, 0,   1, 8'hA5, 1,  0,  0, 0};
    vecs[3] = '{1, 2'b10, 8'h30, 0, 8'h00, 8'h77, 99,  1, 8'hA5, 17, 16, 0, 1};
    vecs[4] = '{3, 2'b10, 8'h33, 1, 8'h5C, 8'h00, 3,   0, 8'hA5, 5,  4,  0, 1};
    vecs[5] = '{3, 2'b00, 8'h40, 1, 8'h99, 8'h00, 0,   1, 8'hA5, 1,  0,  0, 0};
    vecs[6] = '{1, 2'b01, 8'h44, 0, 8'h00, 8'h3C, 1,   0, 8'h3C, 3,  2,  1, 0};

    presetn = 1'b0;
    bus.req = '0; bus.req_slv = '0; bus.req_addr = '0; bus.req_wr = '0; bus.req_wdata = '0;
    bus.prdata = '0; bus.pready = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk);
    check_outputs();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_psel", 32'({bus.psel1, bus.psel2, bus.penable}), 32'd0);
    presetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (2) tick();

    // All four requesters held high: strict rotation with no idle cycle between transfers.
    reset_dut();
    for (int i = 0; i < NR; i++) set_fields(i, 2'b01, AW'(i), 1'b1, DW'(8'hC0 + i));
    bus.req = 4'b1111; bus.pready = 1'b1;
    ng = 0; last_k = 0;
    for (int k = 0; k < 20 && ng < 5; k++) begin
      tick();
      if (bus.gnt != '0) begin
        chk("fair_order", 32'(bus.gnt), 32'd1 << (ng % NR));
        if (ng > 0) chk("fair_gap", 32'(k - last_k), 32'd2);
        last_k = k;
        ng++;
      end
    end
    chk("fair_grants", 32'(ng), 32'd5);
    bus.req = '0;
    repeat (3) tick();
    bus.pready = 1'b0;
    tick();

    // Reset asserted while a transfer waits in ACCESS.
    reset_dut();
    set_fields(1, 2'b01, 8'h55, 1'b0, 8'h00);
    bus.req = 4'b0010;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin tick(); if (bus.gnt != '0) got = 1'b1; end
    chk("rst_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin tick(); if (bus.penable) got = 1'b1; end
    chk("rst_in_access", 32'(bus.penable), 32'd1);
    repeat (3) tick();
    #2 presetn = 1'b0;
    #1;
    chk("rst_async_bus", 32'({bus.psel1, bus.psel2, bus.penable}), 32'd0);
    chk("rst_async_hs", 32'({bus.gnt, bus.done}), 32'd0);
    model_reset();
    @(negedge pclk);
    check_outputs();
    presetn = 1'b1;
    set_fields(0, 2'b10, 8'h66, 1'b1, 8'h42);
    set_fields(3, 2'b01, 8'h77, 1'b1, 8'h24);
    bus.req = 4'b1001;
    tick();
    chk("rst_winner", 32'(bus.gnt), 32'b0001);
    bus.req = '0; bus.pready = 1'b1;
    repeat (3) tick();
    bus.pready = 1'b0;

    // Random traffic against the reference model, with stall windows forcing timeouts.
    for (int i = 0; i < NR; i++) rand_fields(i);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.pready = ((cyc >= 200 && cyc < 240) || (cyc >= 700 && cyc < 730)) ? 1'b0
                   : ($urandom_range(0, 2) != 0);
      bus.prdata = DW'($urandom);
      tick();
      g = bus.gnt;
      for (int i = 0; i < NR; i++) begin
        if (g[IW'(i)]) begin
          bus.req[i +: 1] = 1'($urandom);
          rand_fields(i);
        end else if (!bus.req[IW'(i)] && $urandom_range(0, 5) == 0) begin
          rand_fields(i);
          bus.req[i +: 1] = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
